clock_set_ctrl: RTL and testbench

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

---
 rtl/clock_set_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: mode/adjust controller for a digital clock.
// Two push-buttons are synchronized and debounced. The mode button steps
// RUN -> SET_H -> SET_M -> SET_S -> RUN. The adjust button issues increment
// pulses for the field being edited, with hold-to-repeat.
// Ports:
//   clk, reset        system clock (rising edge), async active-high reset
//   btn_mode, btn_adj raw active-high push-buttons, asynchronous to clk
//   tick_1hz          one-cycle pulse every CLK_HZ cycles while in RUN
//   adj_hour/min/sec  one-cycle increment pulses for the edited field
//   mode              0 RUN, 1 SET_H, 2 SET_M, 3 SET_S
//   blink             display enable for the edited field (1 = show)
module clock_set_ctrl #(
  parameter int unsigned CLK_HZ  = 100000,
  parameter int unsigned DEB_MS  = 20,
  parameter int unsigned HOLD_MS = 500,
  parameter int unsigned RPT_MS  = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_adj,
  output logic       tick_1hz,
  output logic       adj_hour,
  output logic       adj_min,
  output logic       adj_sec,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int unsigned DEB_CYC  = CLK_HZ * DEB_MS / 1000;
  localparam int unsigned HOLD_CYC = CLK_HZ * HOLD_MS / 1000;
  localparam int unsigned RPT_CYC  = CLK_HZ * RPT_MS / 1000;
  localparam int unsigned BLK_CYC  = CLK_HZ / 4;
  localparam int unsigned RPT_MAX  = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;

  localparam int unsigned DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int unsigned SEC_W = (CLK_HZ  > 1) ? $clog2(CLK_HZ)  : 1;
  localparam int unsigned RPT_W = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam int unsigned BLK_W = (BLK_CYC > 1) ? $clog2(BLK_CYC) : 1;

  // Reject parameter sets whose derived timings round down to zero cycles
  if (DEB_CYC == 0 || HOLD_CYC == 0 || RPT_CYC == 0 || BLK_CYC == 0) begin : g_bad_params
    $error("clock_set_ctrl: derived cycle counts must all be >= 1");
  end

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_e;

  // ---------------------------------------------------------------------
  // Button front end: bit 0 = mode, bit 1 = adjust
  // ---------------------------------------------------------------------
  logic [1:0]       btn_raw;
  logic [1:0]       btn_sync1;
  logic [1:0]       btn_sync2;
  logic [1:0]       btn_deb;
  logic [1:0]       btn_deb_q;
  logic [1:0]       btn_press;
  logic [DEB_W-1:0] deb_cnt [2];

  assign btn_raw = {btn_adj, btn_mode};

  // 2-flop synchronizer, counting debouncer and registered rising-edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_sync1 <= '0;
      btn_sync2 <= '0;
      btn_deb   <= '0;
      btn_deb_q <= '0;
      btn_press <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      btn_sync1 <= btn_raw;
      btn_sync2 <= btn_sync1;
      btn_deb_q <= btn_deb;
      btn_press <= btn_deb & ~btn_deb_q;
      for (int i = 0; i < 2; i++) begin
        if (btn_sync2[i] != btn_deb[i]) begin
          if (deb_cnt[i] == DEB_W'(DEB_CYC - 1)) begin
            btn_deb[i] <= btn_sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  logic mode_press;
  logic adj_press;
  logic adj_level;

  assign mode_press = btn_press[0];
  assign adj_press  = btn_press[1];
  assign adj_level  = btn_deb[1];

  // ---------------------------------------------------------------------
  // Mode FSM and output datapath
  // ---------------------------------------------------------------------
  state_e           state;
  state_e           state_nxt;
  logic             mode_chg;
  logic             adj_fire;

  logic [SEC_W-1:0] sec_cnt;
  logic [SEC_W-1:0] sec_cnt_nxt;
  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_cnt_nxt;
  logic [RPT_W-1:0] rpt_lim;
  logic             rpt_arm;
  logic             rpt_arm_nxt;
  logic             rpt_first;
  logic             rpt_first_nxt;
  logic [BLK_W-1:0] blk_cnt;
  logic [BLK_W-1:0] blk_cnt_nxt;

  logic             tick_nxt;
  logic             hour_nxt;
  logic             min_nxt;
  logic             sec_nxt;
  logic             blink_nxt;

  assign mode = state;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Next state, counters and next output values
  always_comb begin
    state_nxt     = state;
    mode_chg      = 1'b0;
    adj_fire      = 1'b0;
    sec_cnt_nxt   = '0;
    tick_nxt      = 1'b0;
    rpt_arm_nxt   = 1'b0;
    rpt_first_nxt = 1'b0;
    rpt_cnt_nxt   = '0;
    rpt_lim       = rpt_first ? RPT_W'(HOLD_CYC - 1) : RPT_W'(RPT_CYC - 1);
    blk_cnt_nxt   = '0;
    blink_nxt     = 1'b1;
    hour_nxt      = 1'b0;
    min_nxt       = 1'b0;
    sec_nxt       = 1'b0;

    // A mode press always wins over a same-cycle adjust press
    if (mode_press) begin
      mode_chg = 1'b1;
      case (state)
        RUN:     state_nxt = SET_H;
        SET_H:   state_nxt = SET_M;
        SET_M:   state_nxt = SET_S;
        default: state_nxt = RUN;
      endcase
    end

    // Seconds prescaler runs only while staying in RUN, otherwise held at 0
    if (state == RUN && !mode_chg) begin
      if (sec_cnt == SEC_W'(CLK_HZ - 1)) tick_nxt = 1'b1;
      else                               sec_cnt_nxt = sec_cnt + SEC_W'(1);
    end

    // Adjust press and hold-to-repeat; any mode change or release disarms
    if (state != RUN && !mode_chg) begin
      if (adj_press) begin
        adj_fire      = 1'b1;
        rpt_arm_nxt   = 1'b1;
        rpt_first_nxt = 1'b1;
      end else if (rpt_arm && adj_level) begin
        rpt_arm_nxt = 1'b1;
        if (rpt_cnt == rpt_lim) begin
          adj_fire = 1'b1;
        end else begin
          rpt_first_nxt = rpt_first;
          rpt_cnt_nxt   = rpt_cnt + RPT_W'(1);
        end
      end
    end

    hour_nxt = adj_fire && (state == SET_H);
    min_nxt  = adj_fire && (state == SET_M);
    sec_nxt  = adj_fire && (state == SET_S);

    // Blink restarts visible on every mode change and every adjust pulse
    if (state != RUN && !mode_chg && !adj_fire) begin
      if (blk_cnt == BLK_W'(BLK_CYC - 1)) begin
        blink_nxt = ~blink;
      end else begin
        blk_cnt_nxt = blk_cnt + BLK_W'(1);
        blink_nxt   = blink;
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_cnt   <= '0;
      rpt_cnt   <= '0;
      rpt_arm   <= 1'b0;
      rpt_first <= 1'b0;
      blk_cnt   <= '0;
      tick_1hz  <= 1'b0;
      adj_hour  <= 1'b0;
      adj_min   <= 1'b0;
      adj_sec   <= 1'b0;
      blink     <= 1'b1;
    end else begin
      sec_cnt   <= sec_cnt_nxt;
      rpt_cnt   <= rpt_cnt_nxt;
      rpt_arm   <= rpt_arm_nxt;
      rpt_first <= rpt_first_nxt;
      blk_cnt   <= blk_cnt_nxt;
      tick_1hz  <= tick_nxt;
      adj_hour  <= hour_nxt;
      adj_min   <= min_nxt;
      adj_sec   <= sec_nxt;
      blink     <= blink_nxt;
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: scoreboard bench for clock_set_ctrl with small timing
// parameters (DEB=4, HOLD=20, RPT=10, BLK=10 cycles, tick every 40).
// Expected mode changes, adjust pulses and blink levels are queued with the
// cycle they are due when a button is driven; a negedge monitor pops and
// compares them. Ticks are expected every 40 cycles after RUN is entered.
module tb_clock_set_ctrl;

  localparam int TICK_CYC  = 40;
  localparam int PRESS_LAT = 7;   // debounce 4 + 3 register stages
  localparam int HOLD_CYC  = 20;
  localparam int RPT_CYC   = 10;
  localparam int BLK_CYC   = 10;

  localparam int K_MODE  = 0;
  localparam int K_BLINK = 1;
  localparam int K_HOUR  = 2;
  localparam int K_MIN   = 3;
  localparam int K_SEC   = 4;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } sb_item_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode;
  logic       btn_adj;
  logic       tick_1hz;
  logic       adj_hour;
  logic       adj_min;
  logic       adj_sec;
  logic [1:0] mode;
  logic       blink;

  sb_item_t   sb[$];
  int         cyc;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         exp_mode = 0;
  int         run_since = 0;

  sb_item_t   mon_it;
  logic [3:0] mon_exp;
  logic [3:0] mon_obs;

  clock_set_ctrl #(
    .CLK_HZ (40),
    .DEB_MS (100),
    .HOLD_MS(500),
    .RPT_MS (250)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_mode(btn_mode),
    .btn_adj (btn_adj),
    .tick_1hz(tick_1hz),
    .adj_hour(adj_hour),
    .adj_min (adj_min),
    .adj_sec (adj_sec),
    .mode    (mode),
    .blink   (blink)
  );

  always #5 clk = ~clk;

  // Edge index since the last reset release: edge n leaves cyc == n
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic sb_push(input int c, input int k, input int v);
    sb_item_t it;
    int       i;
    it.cyc  = c;
    it.kind = k;
    it.val  = v;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, it);
  endtask

  task automatic push_pulse(input int c, input int k);
    sb_push(c, k, 1);
    sb_push(c, K_BLINK, 1);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise the selected buttons at the next negedge; fh is the first edge sampling them
  task automatic start_press(input logic m, input logic a, output int fh);
    @(negedge clk);
    fh = cyc + 1;
    if (m) btn_mode = 1'b1;
    if (a) btn_adj  = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mode"},  32'(mode),     32'd0);
    check({tag, "_tick"},  32'(tick_1hz), 32'd0);
    check({tag, "_hour"},  32'(adj_hour), 32'd0);
    check({tag, "_min"},   32'(adj_min),  32'd0);
    check({tag, "_sec"},   32'(adj_sec),  32'd0);
    check({tag, "_blink"}, 32'(blink),    32'd1);
  endtask

  // Scoreboard monitor, sampled half a cycle after each active edge
  always @(negedge clk) begin
    if (!reset) begin
      mon_exp = 4'b0000;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        mon_it = sb.pop_front();
        case (mon_it.kind)
          K_MODE: begin
            exp_mode = mon_it.val;
            if (mon_it.val == 0) run_since = cyc;
          end
          K_BLINK: check("blink", 32'(blink), 32'(mon_it.val));
          K_HOUR:  mon_exp[2] = 1'b1;
          K_MIN:   mon_exp[1] = 1'b1;
          K_SEC:   mon_exp[0] = 1'b1;
          default: ;
        endcase
      end
      if (exp_mode == 0 && cyc > run_since && ((cyc - run_since) % TICK_CYC) == 0)
        mon_exp[3] = 1'b1;
      mon_obs = {tick_1hz, adj_hour, adj_min, adj_sec};
      if (mon_obs != 4'b0000 || mon_exp != 4'b0000)
        check("pulses{tick,h,m,s}", 32'(mon_obs), 32'(mon_exp));
      check("mode", 32'(mode), 32'(exp_mode));
      if (exp_mode == 0) check("blink_run", 32'(blink), 32'd1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fh;
    int fh2;
    int p;
    int nm;
    int na;

    reset    = 1'b0;
    btn_mode = 1'b0;
    btn_adj  = 1'b0;
    #1 reset = 1'b1;
    #2 check_reset_outputs("reset_no_clk");
    wait_cyc(3);
    reset = 1'b0;

    // Free-running RUN: ticks at 40, 80, ... 200
    wait_cyc(205);

    // Two-cycle bounce on mode is rejected
    start_press(1'b1, 1'b0, fh);
    wait_cyc(2);
    btn_mode = 1'b0;
    wait_cyc(10);

    // Real mode press -> SET_H; blink toggles every BLK_CYC
    start_press(1'b1, 1'b0, fh);
    p = fh + PRESS_LAT;
    sb_push(p, K_MODE, 1);
    sb_push(p, K_BLINK, 1);
    sb_push(p + BLK_CYC, K_BLINK, 0);
    sb_push(p + 2 * BLK_CYC, K_BLINK, 1);
    sb_push(p + 3 * BLK_CYC, K_BLINK, 0);
    wait_cyc(10);
    btn_mode = 1'b0;
    wait_cyc(40);

    // -> SET_M
    start_press(1'b1, 1'b0, fh);
    p = fh + PRESS_LAT;
    sb_push(p, K_MODE, 2);
    sb_push(p, K_BLINK, 1);
    sb_push(p + BLK_CYC, K_BLINK, 0);
    wait_cyc(10);
    btn_mode = 1'b0;
    wait_cyc(15);

    // Adjust held 40 cycles: press pulse, first repeat after HOLD, one more after RPT
    start_press(1'b0, 1'b1, fh);
    p = fh + PRESS_LAT;
    push_pulse(p, K_MIN);
    push_pulse(p + HOLD_CYC, K_MIN);
    push_pulse(p + HOLD_CYC + RPT_CYC, K_MIN);
    sb_push(p + BLK_CYC, K_BLINK, 0);
    sb_push(p + HOLD_CYC + RPT_CYC + BLK_CYC, K_BLINK, 0);
    wait_cyc(40);
    btn_adj = 1'b0;
    wait_cyc(60);

    // -> SET_S
    start_press(1'b1, 1'b0, fh);
    sb_push(fh + PRESS_LAT, K_MODE, 3);
    wait_cyc(10);
    btn_mode = 1'b0;
    wait_cyc(20);

    // Mode and adjust rise together: back to RUN, no adj_sec, tick 40 later
    start_press(1'b1, 1'b1, fh);
    sb_push(fh + PRESS_LAT, K_MODE, 0);
    wait_cyc(10);
    btn_mode = 1'b0;
    btn_adj  = 1'b0;
    wait_cyc(50);

    // -> SET_H, then a mode change while adjust repeats cancels repeat
    start_press(1'b1, 1'b0, fh);
    sb_push(fh + PRESS_LAT, K_MODE, 1);
    sb_push(fh + PRESS_LAT, K_BLINK, 1);
    wait_cyc(10);
    btn_mode = 1'b0;
    wait_cyc(15);
    start_press(1'b0, 1'b1, fh);
    p = fh + PRESS_LAT;
    push_pulse(p, K_HOUR);
    push_pulse(p + HOLD_CYC, K_HOUR);
    wait_cyc(24);
    start_press(1'b1, 1'b0, fh2);
    sb_push(fh2 + PRESS_LAT, K_MODE, 2);
    sb_push(fh2 + PRESS_LAT, K_BLINK, 1);
    wait_cyc(10);
    btn_mode = 1'b0;
    wait_cyc(30);
    btn_adj = 1'b0;
    wait_cyc(20);

    // Reset asserted mid-repeat in SET_M
    start_press(1'b0, 1'b1, fh);
    p = fh + PRESS_LAT;
    push_pulse(p, K_MIN);
    push_pulse(p + HOLD_CYC, K_MIN);
    wait_cyc(p + HOLD_CYC + 5 - cyc);
    check("pre_reset_mode", 32'(mode), 32'd2);
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_reset");
    btn_adj = 1'b0;
    sb.delete();
    exp_mode  = 0;
    run_since = 0;
    wait_cyc(3);
    check_reset_outputs("reset_hold");
    reset = 1'b0;
    wait_cyc(85);

    // Mode button held through reset release: press event DEB+3 after edge 1
    @(negedge clk);
    reset    = 1'b1;
    btn_mode = 1'b1;
    sb.delete();
    exp_mode  = 0;
    run_since = 0;
    sb_push(1 + PRESS_LAT, K_MODE, 1);
    sb_push(1 + PRESS_LAT, K_BLINK, 1);
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(10);
    btn_mode = 1'b0;
    wait_cyc(20);

    // Bounce on both buttons, every run shorter than the debounce time
    nm = int'($urandom_range(3, 1));
    na = int'($urandom_range(3, 1));
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      nm--;
      na--;
      if (nm == 0) begin
        btn_mode = ~btn_mode;
        nm = int'($urandom_range(3, 1));
      end
      if (na == 0) begin
        btn_adj = ~btn_adj;
        na = int'($urandom_range(3, 1));
      end
    end
    btn_mode = 1'b0;
    btn_adj  = 1'b0;
    wait_cyc(20);
    check("post_bounce_mode", 32'(mode), 32'd1);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
